// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
//  arb_state_e   : arbiter FSM states (idle, latch, strobe, settle)
//  SETTLE_CNT_W  : width of the settle-window counter (SETTLE_CYCLES up to 255)
//  idx_width()   : width of a requester index for a given requester count
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StStrobe,
    StSettle
  } arb_state_e;

  localparam int unsigned SETTLE_CNT_W = 8;

  function automatic int unsigned idx_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at last+1 (mod N_REQ) and returns the first set index.
// Ports:
//  req     in   N_REQ   request vector
//  last    in   IDX_W   index granted last; search starts one above it
//  winner  out  IDX_W   first requesting index after last (last when none)
//  any     out  1       at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] idx;
    winner = last;
    any    = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = (32'(last) + k) % N_REQ;
      idx = pos[IDX_W-1:0];
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the write port of one edge-triggered FIFO.
// Each grant latches the winner's word, drives a one-cycle write strobe
// (preceded by a guaranteed low cycle), then waits SETTLE_CYCLES so the FIFO
// counter and full flag reflect the write before the next grant.
// Optional feature macro FIFO_ARB_HIPRI_EN: requester 0 gets strict priority,
// the others rotate among themselves.
// Ports:
//  clk           in   clock
//  rst           in   asynchronous reset, active-high
//  req_valid     in   per-requester word available
//  req_data      in   requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ack       out  one-cycle pulse, word of grant_idx accepted
//  fifo_din      out  data to FIFO, held from grant until the next grant
//  fifo_wr_en    out  single-cycle write strobe
//  fifo_full     in   FIFO full flag
//  fifo_counter  in   FIFO occupancy
//  grant_idx     out  index of last/current grant
//  busy          out  high whenever the FSM is not idle
//  almost_full   out  registered (fifo_counter >= AFULL_LVL)
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned BUF_WIDTH     = 5,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned AFULL_LVL     = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ack,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic [BUF_WIDTH:0]            fifo_counter,
  output logic [idx_width(N_REQ)-1:0]   grant_idx,
  output logic                          busy,
  output logic                          almost_full
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  arb_state_e              state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick_win;
  logic             pick_any;
  logic [IDX_W-1:0] winner;
  logic             win_any;
  logic             can_grant;

`ifdef FIFO_ARB_HIPRI_EN
  // Rotation pointer for requesters 1..N_REQ-1; priority grants to 0 leave it alone.
  logic [IDX_W-1:0] rr_last;

  assign pick_req  = {req_valid[N_REQ-1:1], 1'b0};
  assign pick_last = rr_last;
  assign winner    = req_valid[0] ? '0 : pick_win;
  assign win_any   = req_valid[0] | pick_any;
`else
  assign pick_req  = req_valid;
  assign pick_last = grant_idx;
  assign winner    = pick_win;
  assign win_any   = pick_any;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (pick_req),
    .last   (pick_last),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Counter MSB set means occupancy has reached the full depth.
  assign can_grant = win_any && !fifo_full && !fifo_counter[BUF_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      settle_cnt  <= '0;
      req_ack     <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= '0;
      grant_idx   <= IDX_W'(N_REQ - 1);
      busy        <= 1'b0;
      almost_full <= 1'b0;
`ifdef FIFO_ARB_HIPRI_EN
      rr_last     <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      almost_full <= 32'(fifo_counter) >= AFULL_LVL;
      req_ack     <= '0;
      fifo_wr_en  <= 1'b0;
      case (state)
        StIdle: begin
          if (can_grant) begin
            grant_idx <= winner;
            fifo_din  <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
            busy      <= 1'b1;
            state     <= StLatch;
`ifdef FIFO_ARB_HIPRI_EN
            if (winner != '0) rr_last <= winner;
`endif
          end
        end
        StLatch: begin
          // wr_en stayed low this cycle, so the strobe below is a clean rising edge.
          fifo_wr_en         <= 1'b1;
          req_ack[grant_idx] <= 1'b1;
          state              <= StStrobe;
        end
        StStrobe: begin
          settle_cnt <= '0;
          state      <= StSettle;
        end
        StSettle: begin
          if (32'(settle_cnt) == SETTLE_CYCLES - 1) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
